// File: rtl/router_pkg.sv
// Shared types and constants for the router input arbiter and its round-robin picker.
package router_pkg;

    localparam int unsigned NSRC     = 3;
    localparam int unsigned SRC_W    = 2;
    localparam int unsigned LEN_W    = 6;
    localparam int unsigned ADDR_LSB = 0;
    localparam int unsigned LEN_LSB  = 2;
    localparam logic [LEN_W-1:0] LEN_MAX = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2
    } state_t;

    // Index of the set bit in a one-hot source vector.
    function automatic logic [SRC_W-1:0] onehot_idx(input logic [NSRC-1:0] oh);
        logic [SRC_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (oh[i]) idx = SRC_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/router_rr_pick.sv
// Combinational three-way round-robin picker: the first requester after `last`, wrapping, wins.
module router_rr_pick
    import router_pkg::*;
(
    input  logic [NSRC-1:0]  req,
    input  logic [SRC_W-1:0] last,
    output logic [NSRC-1:0]  win
);

    logic [NSRC-1:0] rot;
    logic [NSRC-1:0] pick;

    // Rotate so bit 0 is the highest-priority source, take the lowest set bit, rotate back.
    always_comb begin
        case (last)
            2'd0:    rot = {req[0], req[2], req[1]};
            2'd1:    rot = {req[1], req[0], req[2]};
            default: rot = req;
        endcase
        pick = rot & (~rot + NSRC'(1));
        case (last)
            2'd0:    win = {pick[1], pick[0], pick[2]};
            2'd1:    win = {pick[0], pick[2], pick[1]};
            default: win = pick;
        endcase
    end

endmodule

// File: rtl/router_in_arb.sv
// Packet-level round-robin arbiter feeding the router input byte stream from three sources.
// Build option: define ROUTER_ARB_LEN_CHECK_EN to compile in the payload length check.
module router_in_arb #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NSRC   = 3
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [NSRC-1:0]        src_pkt_vd,
    input  logic [NSRC*DATA_W-1:0] src_data,
    output logic [NSRC-1:0]        src_ready,
    input  logic                   busy,
    output logic                   pkt_vd,
    output logic [DATA_W-1:0]      data_out,
    output logic [NSRC-1:0]        grant,
    output logic                   pkt_done,
    output logic                   len_err
);
    import router_pkg::*;

    state_t            state, state_n;
    logic [NSRC-1:0]   grant_n;
    logic [SRC_W-1:0]  last, last_n;
    logic [NSRC-1:0]   win;
    logic              active;
    logic              vd_g;
    logic [DATA_W-1:0] data_g;
    logic              xfer;
    logic              parity_xfer;

    router_rr_pick u_pick (
        .req  (src_pkt_vd),
        .last (last),
        .win  (win)
    );

    // Byte stream of the current owner; grant is zero while idle.
    always_comb begin
        vd_g   = 1'b0;
        data_g = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (grant[i]) begin
                vd_g   = src_pkt_vd[i];
                data_g = src_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // A withdrawn header is not a transfer; in payload a low valid marks the parity byte.
    assign active      = rstn && (state != IDLE);
    assign xfer        = active && !busy && ((state == PAYLOAD) || vd_g);
    assign parity_xfer = xfer && (state == PAYLOAD) && !vd_g;

    assign pkt_vd    = active && vd_g;
    assign data_out  = active ? data_g : '0;
    assign src_ready = xfer ? grant : '0;
    assign pkt_done  = parity_xfer;

    always_comb begin
        state_n = state;
        grant_n = grant;
        last_n  = last;
        case (state)
            IDLE: begin
                if (|src_pkt_vd) begin
                    grant_n = win;
                    last_n  = onehot_idx(win);
                    state_n = HEADER;
                end
            end
            HEADER: begin
                if (!vd_g) begin
                    grant_n = '0;
                    state_n = IDLE;
                end else if (!busy) begin
                    state_n = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (parity_xfer) begin
                    grant_n = '0;
                    state_n = IDLE;
                end
            end
            default: begin
                grant_n = '0;
                state_n = IDLE;
            end
        endcase
    end

    // Reset leaves source 0 with top priority.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
            grant <= '0;
            last  <= SRC_W'(2);
        end else begin
            state <= state_n;
            grant <= grant_n;
            last  <= last_n;
        end
    end

`ifdef ROUTER_ARB_LEN_CHECK_EN
    logic             hdr_xfer;
    logic             pay_xfer;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt_q;

    assign hdr_xfer = xfer && (state == HEADER);
    assign pay_xfer = xfer && (state == PAYLOAD) && vd_g;

    // Payload counter saturates, so a 63-byte payload still matches len 63.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            len_q <= '0;
            cnt_q <= '0;
        end else if (hdr_xfer) begin
            len_q <= data_g[LEN_LSB +: LEN_W];
            cnt_q <= '0;
        end else if (pay_xfer && (cnt_q != LEN_MAX)) begin
            cnt_q <= cnt_q + LEN_W'(1);
        end
    end

    assign len_err = parity_xfer && (cnt_q != len_q);
`else
    assign len_err = 1'b0;
`endif

endmodule

// File: doc/router_in_arb.md
# router_in_arb

Packet-level round-robin arbiter sitting in front of the 1x3 router input port. Three upstream packet sources share the single router input byte stream (`pkt_vd`/`data`). A granted source keeps the port for a whole packet: header, payload, parity. The block honours the router's `busy` back-pressure and optionally checks payload length against the header length field.

## Interface

Parameters:
- `DATA_W`, 8: byte width. Header layout is addr[1:0], len[7:2].
- `NSRC`, 3: number of sources. Fixed at 3; other values are unsupported.

Ports (all active-high unless noted):
- `clk` in 1: clock.
- `rstn` in 1: reset, synchronous, active-low.
- `src_pkt_vd` in NSRC: per-source packet valid. High on header and payload bytes, low on the parity byte.
- `src_data` in NSRC*DATA_W: per-source byte. Source i occupies bits [i*8+7:i*8].
- `src_ready` out NSRC: byte from source i is transferred this cycle.
- `busy` in 1: router FSM busy. No transfer occurs while high.
- `pkt_vd` out 1: router packet valid.
- `data_out` out DATA_W: router data byte.
- `grant` out NSRC: one-hot owner of the port. Registered.
- `pkt_done` out 1: one-cycle pulse on the parity transfer.
- `len_err` out 1: one-cycle pulse on the parity transfer when the length mismatches.

## Operation

States: IDLE, HEADER, PAYLOAD.

IDLE
- `grant` = 0.
- If any `src_pkt_vd` is high, pick a winner round-robin. Search starts at `last+1` mod 3.
- Register the winner into `grant` and `last`, then go to HEADER.
- With no request, stay in IDLE.

HEADER
- `src_ready[g]` = !busy.
- On transfer with `src_pkt_vd[g]`=1: forward the header, latch len = data[7:2], clear the payload counter, go to PAYLOAD.
- If `src_pkt_vd[g]`=0 here (source withdrew): no transfer, go to IDLE, no error. `last` stays updated.

PAYLOAD
- `src_ready[g]` = !busy.
- Transfer with `src_pkt_vd[g]`=1: payload byte. Counter += 1, saturating at 63.
- Transfer with `src_pkt_vd[g]`=0: parity byte. Pulse `pkt_done`, go to IDLE.

Datapath
- `pkt_vd` = (state != IDLE) & `src_pkt_vd[g]`.
- `data_out` = `src_data[g]` when state != IDLE, else 0.
- Both are combinational from the registered grant.
- Non-granted sources always see `src_ready`=0. Their valid/data are ignored and must be held by the source.

Rules
- Source rule: data and valid stay stable until `src_ready` is seen.
- Bubble: at least one IDLE cycle separates the parity of one packet and the header of the next. Throughput is therefore (len+3) cycles per packet when `busy` is low.
- Length 0: parity directly follows the header. A count of 0 matches.

Reset mid-packet
- Go to IDLE. Clear `grant`, counter, pulses.
- Set `last`=2, so source 0 has top priority after reset.
- A partial packet is abandoned. The source must restart it.

## Timing

- Reset values: `grant`=0, `src_ready`=0, `pkt_vd`=0, `data_out`=0, `pkt_done`=0, `len_err`=0, state=IDLE, `last`=2.
- Arbitration latency: a request seen in IDLE at cycle n gets `grant` at n+1. The earliest header transfer is at n+1.
- `busy` high at cycle n means no transfer at n. State and counter hold. The source holds its byte.
- `pkt_done`/`len_err` are asserted in the same cycle as the parity transfer: combinational from the current-state transfer, not registered afterwards.
- Simultaneous requests: exactly one grant, chosen by rotation.
- A request that rises during another's packet waits until the next IDLE.

## Configuration

`ROUTER_ARB_LEN_CHECK_EN`
- Defined: the 6-bit payload counter and len register are compiled in. `len_err` = parity transfer & (count != len). A count saturated at 63 with len=63 counts as a match.
- Undefined: counter and len register are removed, and `len_err` is tied 0. `pkt_done` and all other behaviour are unchanged.

## Structure

- Shared package `router_pkg`:
  - state enum (IDLE/HEADER/PAYLOAD)
  - `NSRC`=3, `LEN_W`=6
  - header field positions `ADDR_LSB`=0, `LEN_LSB`=2
- One sub-module, `router_rr_pick`: combinational 3-way round-robin picker. Inputs are the request vector and `last`; output is a one-hot winner. It is instantiated once in IDLE.

## Test plan

- Single source 1, header 0x09 (len 2, addr 1), payload AA BB, parity P, `busy`=0 -> `grant`=010 at cycle 1; `pkt_vd` 1,1,1,0 with data 09,AA,BB,P; `pkt_done` on the P cycle; `len_err`=0.
- All three sources request at once after reset -> packets served in order 0, 1, 2, then 0 again; exactly one IDLE cycle between each parity and the next header.
- `busy` held high for 3 cycles right after the header transfer -> `src_ready`=0 and `data_out` stable for those cycles; the payload byte transfers on the first cycle with `busy` low; no byte is duplicated or lost.
- Header 0x0C (len 3) with only 2 payload bytes, macro defined -> `len_err`=1 on the parity cycle. Same case with the macro undefined -> `len_err`=0.
- `rstn`=0 for one cycle during source 2's payload -> next cycle `grant`=0, `pkt_vd`=0; requests from 0 and 2 afterwards -> source 0 is granted first.
- Source 0 drops `src_pkt_vd` in HEADER before any transfer -> no bytes forwarded, return to IDLE, a pending source 1 is granted next.
